fifth_mem_bus: RTL and testbench

- Data-memory and I/O subsystem directly downstream of the fifth core's memory port: it consumes mem_address / mem_write_enable / mem_data_output and produces mem_data_input.
- Contains the data RAM, a memory-mapped UART transmitter with a TX FIFO, an optional UART receiver, and a free-running tick counter.
- Read data is registered (one-cycle latency), which matches the core's fetch timing: address presented in cycle N is consumed as T_next in cycle N+1.

---
 rtl/fifth_bus_pkg.sv | 23 ++
 rtl/fifth_uart_tx.sv | 96 +++++++++
 rtl/fifth_mem_bus.sv | 229 ++++++++++++++++++++++
 tb/tb_fifth_mem_bus.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifth_bus_pkg.sv
// Shared constants and types for the fifth core's data-memory / I/O bus.
package fifth_bus_pkg;

  localparam logic [3:0] IO_PAGE = 4'hF;

  localparam int unsigned IO_OFF_W = 12;
  localparam logic [IO_OFF_W-1:0] ADDR_TXDATA = 12'h000;
  localparam logic [IO_OFF_W-1:0] ADDR_STATUS = 12'h001;
  localparam logic [IO_OFF_W-1:0] ADDR_RXDATA = 12'h002;
  localparam logic [IO_OFF_W-1:0] ADDR_CTRL   = 12'h003;
  localparam logic [IO_OFF_W-1:0] ADDR_TICKS  = 12'h004;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_TX_BUSY    = 2;
  localparam int unsigned ST_RX_VALID   = 3;
  localparam int unsigned ST_RX_OVERRUN = 4;
  localparam int unsigned ST_TX_OVF     = 5;
  localparam int unsigned ST_RX_FERR    = 6;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/fifth_uart_tx.sv
// UART transmitter: 8N1 framing, pops one byte from the TX FIFO per frame.
module fifth_uart_tx
  import fifth_bus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pop_valid,
  input  logic [7:0] pop_data,
  output logic       pop_ready_c,
  output logic       busy_c,
  output logic       uart_tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_d;

  // Reset drives the line idle immediately, abandoning any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      uart_tx <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      uart_tx <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    tx_d        = uart_tx;
    pop_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        pop_ready_c = 1'b1;
        tx_d        = 1'b1;
        if (pop_valid) begin
          state_d = START;
          sh_d    = pop_data;
          cnt_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_c = (state_q != IDLE);

endmodule

// File: rtl/fifth_mem_bus.sv
// Data RAM plus memory-mapped UART / tick counter behind the fifth core.
// Define FIFTH_UART_RX_EN to compile in the UART receiver.
module fifth_mem_bus
  import fifth_bus_pkg::*;
#(
  parameter int unsigned RAM_AW       = 12,
  parameter int unsigned TXF_AW       = 3,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_write_enable,
  input  logic [15:0] mem_data_output,
  output logic [15:0] mem_data_input,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
  localparam int unsigned TXF_DEPTH = 2 ** TXF_AW;
  localparam int unsigned TXC_W     = TXF_AW + 1;
  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);

  logic                io_sel_c;
  logic [IO_OFF_W-1:0] io_off_c;
  logic [RAM_AW-1:0]   ram_addr_c;
  logic                io_we_c;
  logic                tx_push_c, rx_clr_c, ctrl_wr_c, ticks_wr_c;

  assign io_sel_c   = (mem_address[15:12] == IO_PAGE);
  assign io_off_c   = mem_address[11:0];
  assign ram_addr_c = mem_address[RAM_AW-1:0];
  assign io_we_c    = mem_write_enable && io_sel_c;
  assign tx_push_c  = io_we_c && (io_off_c == ADDR_TXDATA);
  assign rx_clr_c   = io_we_c && (io_off_c == ADDR_RXDATA);
  assign ctrl_wr_c  = io_we_c && (io_off_c == ADDR_CTRL);
  assign ticks_wr_c = io_we_c && (io_off_c == ADDR_TICKS);

  logic [15:0] ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_write_enable && !io_sel_c) ram[ram_addr_c] <= mem_data_output;
  end

  // TX FIFO: a pop frees a slot in time for a same-cycle push when full.
  logic [7:0]        txf_mem [TXF_DEPTH];
  logic [TXF_AW-1:0] txf_wr_q, txf_rd_q;
  logic [TXC_W-1:0]  txf_cnt_q;
  logic              tx_full_c, tx_empty_c, tx_ready_c, tx_pop_c, tx_push_ok_c;
  logic              tx_busy_c, tx_overflow_q;

  assign tx_full_c    = (txf_cnt_q == TXC_W'(TXF_DEPTH));
  assign tx_empty_c   = (txf_cnt_q == '0);
  assign tx_pop_c     = !tx_empty_c && tx_ready_c;
  assign tx_push_ok_c = tx_push_c && (!tx_full_c || tx_pop_c);

  always_ff @(posedge clk) begin
    if (tx_push_ok_c) txf_mem[txf_wr_q] <= mem_data_output[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txf_wr_q      <= '0;
      txf_rd_q      <= '0;
      txf_cnt_q     <= '0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (tx_push_ok_c) txf_wr_q <= txf_wr_q + 1'b1;
      if (tx_pop_c)     txf_rd_q <= txf_rd_q + 1'b1;
      if (tx_push_ok_c && !tx_pop_c)      txf_cnt_q <= txf_cnt_q + 1'b1;
      else if (!tx_push_ok_c && tx_pop_c) txf_cnt_q <= txf_cnt_q - 1'b1;
      if (ctrl_wr_c && mem_data_output[0]) tx_overflow_q <= 1'b0;
      if (tx_push_c && !tx_push_ok_c)      tx_overflow_q <= 1'b1;
    end
  end

  fifth_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .reset      (reset),
    .pop_valid  (!tx_empty_c),
    .pop_data   (txf_mem[txf_rd_q]),
    .pop_ready_c(tx_ready_c),
    .busy_c     (tx_busy_c),
    .uart_tx    (uart_tx)
  );

  logic [15:0] ticks_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          ticks_q <= '0;
    else if (ticks_wr_c) ticks_q <= mem_data_output;
    else                 ticks_q <= ticks_q + 16'd1;
  end

  logic       rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] rx_byte;

`ifdef FIFTH_UART_RX_EN
  localparam logic [CNT_W-1:0] RX_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [2:0]       rx_sync_q;
  logic             rx_line_c, rx_good_c, rx_ferr_c;

  // rx_sync_q[1:0] is the synchronizer; [2] holds the previous synced level.
  assign rx_line_c = rx_sync_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_q    <= '1;
      rx_state_q   <= IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      if (rx_clr_c) begin
        rx_valid     <= 1'b0;
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      // A byte landing with a same-cycle clear wins without flagging overrun.
      if (rx_good_c) begin
        rx_byte  <= rx_sh_q;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_clr_c) rx_overrun <= 1'b1;
      end
      if (rx_ferr_c) rx_frame_err <= 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_good_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_sync_q[2] && !rx_line_c) begin
          rx_state_d = START;
          rx_cnt_d   = '0;
        end
      end
      START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == RX_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line_c ? IDLE : DATA;
        end
      end
      DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_line_c, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end
      end
      STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == RX_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = IDLE;
          rx_good_c  = rx_line_c;
          rx_ferr_c  = !rx_line_c;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end
`else
  logic unused_rx;
  assign unused_rx    = uart_rx ^ rx_clr_c;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = '0;
`endif

  logic [15:0] status_c, io_rdata_c;

  always_comb begin
    status_c                = '0;
    status_c[ST_TX_FULL]    = tx_full_c;
    status_c[ST_TX_EMPTY]   = tx_empty_c;
    status_c[ST_TX_BUSY]    = tx_busy_c;
    status_c[ST_RX_VALID]   = rx_valid;
    status_c[ST_RX_OVERRUN] = rx_overrun;
    status_c[ST_TX_OVF]     = tx_overflow_q;
    status_c[ST_RX_FERR]    = rx_frame_err;
  end

  always_comb begin
    io_rdata_c = '0;
    case (io_off_c)
      ADDR_STATUS: io_rdata_c = status_c;
      ADDR_RXDATA: io_rdata_c = {8'h00, rx_byte};
      ADDR_TICKS:  io_rdata_c = ticks_q;
      default:     io_rdata_c = '0;
    endcase
  end

  // Registered read path: RAM returns pre-write data on a same-address store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        mem_data_input <= '0;
    else if (io_sel_c) mem_data_input <= io_rdata_c;
    else               mem_data_input <= ram[ram_addr_c];
  end

endmodule

// File: tb/tb_fifth_mem_bus.sv
// Directed bench for fifth_mem_bus with CLKS_PER_BIT=4.
module tb_fifth_mem_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_address;
  logic        mem_write_enable;
  logic [15:0] mem_data_output;
  logic [15:0] mem_data_input;
  logic        uart_tx;
  logic        uart_rx;

  int total = 0;
  int bad   = 0;

  logic       mon_en;
  logic [7:0] mon_q [$];
  logic [7:0] exp_bytes [10];
  logic [7:0] a5 = 8'hA5;

  fifth_mem_bus #(
    .RAM_AW      (12),
    .TXF_AW      (3),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_write_enable(mem_write_enable),
    .mem_data_output (mem_data_output),
    .mem_data_input  (mem_data_input),
    .uart_tx         (uart_tx),
    .uart_rx         (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_address      = a;
    mem_data_output  = d;
    mem_write_enable = 1'b1;
    tick();
    mem_write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    mem_address = a;
    tick();
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) tick();
    end
    uart_rx = stop_bit;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (6) tick();
  endtask

  // Serial monitor: samples each bit mid-cell, keeps frames with a good stop bit.
  always begin : tx_mon
    logic [7:0] b;
    logic       s;
    @(negedge clk);
    if (mon_en && reset && uart_tx === 1'b0) begin
      repeat (6) @(negedge clk);
      b[0] = uart_tx;
      for (int i = 1; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (4) @(negedge clk);
      s = uart_tx;
      if (mon_en && s) mon_q.push_back(b);
    end
  end

  initial begin
    reset            = 1'b0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_data_output  = '0;
    uart_rx          = 1'b1;
    mon_en           = 1'b0;
    repeat (3) tick();
    check("reset_uart_tx", 16'(uart_tx), 16'h0001);
    check("reset_rdata", mem_data_input, 16'h0000);

    reset       = 1'b1;
    mem_address = 16'hF004;
    tick();
    check("ticks_after_reset", mem_data_input, 16'h0000);
    tick();
    check("ticks_incr", mem_data_input, 16'h0001);
    rd(16'hF001);
    check("status_reset", mem_data_input, 16'h0002);
    rd(16'hF000);
    check("txdata_reads_zero", mem_data_input, 16'h0000);
    rd(16'hF00F);
    check("unmapped_io_zero", mem_data_input, 16'h0000);

    // RAM: registered read, read-during-write old data, aliasing
    wr(16'h0010, 16'h1111);
    wr(16'h0010, 16'h1234);
    check("ram_rdw_old", mem_data_input, 16'h1111);
    rd(16'h0010);
    check("ram_read", mem_data_input, 16'h1234);
    rd(16'h1010);
    check("ram_alias", mem_data_input, 16'h1234);
    wr(16'hEFFF, 16'hBEEF);
    rd(16'h0FFF);
    check("ram_alias_top", mem_data_input, 16'hBEEF);
    wr(16'hF010, 16'hDEAD);
    rd(16'h0010);
    check("io_write_no_ram", mem_data_input, 16'h1234);

    // TX frame of 0xA5
    mon_q.delete();
    mon_en = 1'b1;
    wr(16'hF000, 16'h00A5);
    check("tx_idle_after_push", 16'(uart_tx), 16'h0001);
    mem_address = 16'hF001;
    tick();
    check("tx_start_bit", 16'(uart_tx), 16'h0000);
    check("status_pre_pop", mem_data_input, 16'h0000);
    tick();
    check("status_busy", mem_data_input, 16'h0006);
    tick();
    tick();
    check("tx_start_hold", 16'(uart_tx), 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("tx_bit%0d", i), 16'(uart_tx), 16'(a5[i]));
      repeat (3) tick();
    end
    tick();
    check("tx_stop_bit", 16'(uart_tx), 16'h0001);
    repeat (5) tick();
    check("status_after_frame", mem_data_input, 16'h0002);
    check("mon_a5_count", 16'(mon_q.size()), 16'h0001);
    if (mon_q.size() > 0) check("mon_a5_byte", {8'h00, mon_q[0]}, 16'h00A5);

    // TICKS load and wrap
    wr(16'hF004, 16'hFFFE);
    tick();
    check("ticks_loaded", mem_data_input, 16'hFFFE);
    tick();
    check("ticks_ffff", mem_data_input, 16'hFFFF);
    tick();
    check("ticks_wrap", mem_data_input, 16'h0000);

    // Overflow: one byte in flight, 8 fill the FIFO, the 9th drops
    mon_q.delete();
    wr(16'hF000, 16'h0011);
    for (int k = 0; k < 9; k++) wr(16'hF000, 16'(8'h20 + k));
    rd(16'hF001);
    check("status_overflow", mem_data_input, 16'h0025);
    wr(16'hF003, 16'h0001);
    rd(16'hF001);
    check("status_ovf_cleared", mem_data_input, 16'h0005);
    // Push lands on the edge the FSM pops while the FIFO is full
    repeat (29) tick();
    wr(16'hF000, 16'h0099);
    rd(16'hF001);
    check("full_push_pop", mem_data_input, 16'h0005);
    for (int n = 0; n < 900 && mon_q.size() < 10; n++) tick();
    repeat (60) tick();
    exp_bytes[0] = 8'h11;
    for (int j = 1; j < 9; j++) exp_bytes[j] = 8'(8'h1F + j);
    exp_bytes[9] = 8'h99;
    check("ovf_frame_count", 16'(mon_q.size()), 16'd10);
    for (int j = 0; j < 10; j++)
      if (j < mon_q.size()) check($sformatf("ovf_byte%0d", j), {8'h00, mon_q[j]}, {8'h00, exp_bytes[j]});
    rd(16'hF001);
    check("status_drained", mem_data_input, 16'h0002);

`ifdef FIFTH_UART_RX_EN
    rx_send(8'h3C, 1'b1);
    rd(16'hF001);
    check("rx_valid", mem_data_input, 16'h000A);
    rd(16'hF002);
    check("rx_data", mem_data_input, 16'h003C);
    rx_send(8'h5A, 1'b1);
    rd(16'hF001);
    check("rx_overrun", mem_data_input, 16'h001A);
    wr(16'hF002, 16'h0000);
    rd(16'hF001);
    check("rx_cleared", mem_data_input, 16'h0002);
    rx_send(8'h77, 1'b0);
    rd(16'hF001);
    check("rx_frame_err", mem_data_input, 16'h0042);
    rd(16'hF002);
    check("rx_byte_kept", mem_data_input, 16'h005A);
`else
    uart_rx = 1'b0;
    repeat (50) tick();
    rd(16'hF001);
    check("rx_absent_status", mem_data_input, 16'h0002);
    rd(16'hF002);
    check("rx_absent_data", mem_data_input, 16'h0000);
    uart_rx = 1'b1;
`endif

    // Reset during DATA of a 0x00 frame
    mon_en = 1'b0;
    wr(16'hF000, 16'h0000);
    repeat (10) tick();
    check("tx_data_low", 16'(uart_tx), 16'h0000);
    #2 reset = 1'b0;
    #1;
    check("tx_async_reset", 16'(uart_tx), 16'h0001);
    check("rdata_async_reset", mem_data_input, 16'h0000);
    tick();
    tick();
    reset = 1'b1;
    rd(16'hF001);
    check("status_after_reset", mem_data_input, 16'h0002);
    repeat (50) tick();
    check("tx_idle_after_reset", 16'(uart_tx), 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
